ps2_tank_controls: RTL and testbench

Upstream input stage for game_engine. Receives PS/2 keyboard frames and decodes Set-2 make/break scan codes. Maintains held-key levels for both players' direction and fire inputs, and drives up1..fire1 and up2..fire2 directly.
Player 1 uses W/A/S/D plus Space. Player 2 uses the arrow keys plus Enter.

---
 rtl/ps2_tank_controls_if.sv | 76 +++++++
 rtl/ps2_tank_controls.sv | 269 ++++++++++++++++++++++++++
 tb/tb_ps2_tank_controls.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_tank_controls_if.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tank_controls_if
//  Description : Bundle of the PS/2 line inputs and the decoded game-control
//                outputs of ps2_tank_controls.
//                  master : keyboard / consumer side. Drives ps2_clk and
//                           ps2_data, observes the decoded outputs.
//                  slave  : the decoder. Observes the PS/2 lines and drives
//                           the key levels, scan_code, scan_valid and
//                           frame_err.
//  Signals     : ps2_clk, ps2_data        asynchronous PS/2 lines
//                up1/down1/left1/right1/fire1   player 1 held keys
//                up2/down2/left2/right2/fire2   player 2 held keys
//                scan_code[7:0]           last correctly received byte
//                scan_valid               1-cycle pulse when scan_code updates
//                frame_err                1-cycle pulse on a bad/aborted frame
//  Revision    : 1.0  initial release
// ============================================================================
interface ps2_tank_controls_if;

    logic       ps2_clk;
    logic       ps2_data;

    logic       up1;
    logic       down1;
    logic       left1;
    logic       right1;
    logic       fire1;
    logic       up2;
    logic       down2;
    logic       left2;
    logic       right2;
    logic       fire2;

    logic [7:0] scan_code;
    logic       scan_valid;
    logic       frame_err;

    modport master (
        output ps2_clk,
        output ps2_data,
        input  up1,
        input  down1,
        input  left1,
        input  right1,
        input  fire1,
        input  up2,
        input  down2,
        input  left2,
        input  right2,
        input  fire2,
        input  scan_code,
        input  scan_valid,
        input  frame_err
    );

    modport slave (
        input  ps2_clk,
        input  ps2_data,
        output up1,
        output down1,
        output left1,
        output right1,
        output fire1,
        output up2,
        output down2,
        output left2,
        output right2,
        output fire2,
        output scan_code,
        output scan_valid,
        output frame_err
    );

endinterface
`default_nettype wire

// File: rtl/ps2_tank_controls.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_tank_controls
//  Description : PS/2 keyboard front end for the tank game. Synchronizes and
//                de-glitches the PS/2 clock, receives 11-bit frames, and
//                decodes Set-2 make/break codes into held-key levels for two
//                players (W/A/S/D + Space, arrows + Enter).
//  Ports       : clk        system clock
//                reset      synchronous, active-high reset
//                bus        ps2_tank_controls_if.slave
//                             in : ps2_clk, ps2_data
//                             out: up1..fire1, up2..fire2, scan_code,
//                                  scan_valid, frame_err
//  Parameters  : FILTER_LEN     equal synchronized ps2_clk samples needed
//                               before the filtered clock changes state
//                TIMEOUT_CYCLES clk cycles without a filtered fall inside a
//                               frame before the frame is aborted
//  Revision    : 1.0  initial release
// ============================================================================
module ps2_tank_controls #(
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  wire logic          clk,
    input  wire logic          reset,
    ps2_tank_controls_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_FCW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int c_TCW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [c_FCW-1:0] c_FILT_LAST = c_FCW'(FILTER_LEN - 1);
    localparam logic [c_TCW-1:0] c_TMO_LAST  = c_TCW'(TIMEOUT_CYCLES - 1);

    // Bit positions of the held-key vector
    localparam logic [3:0] c_K_UP1    = 4'd0;
    localparam logic [3:0] c_K_DOWN1  = 4'd1;
    localparam logic [3:0] c_K_LEFT1  = 4'd2;
    localparam logic [3:0] c_K_RIGHT1 = 4'd3;
    localparam logic [3:0] c_K_FIRE1  = 4'd4;
    localparam logic [3:0] c_K_UP2    = 4'd5;
    localparam logic [3:0] c_K_DOWN2  = 4'd6;
    localparam logic [3:0] c_K_LEFT2  = 4'd7;
    localparam logic [3:0] c_K_RIGHT2 = 4'd8;
    localparam logic [3:0] c_K_FIRE2  = 4'd9;

    localparam logic [7:0] c_CODE_EXT = 8'hE0;
    localparam logic [7:0] c_CODE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } rx_state_t;

    // ------------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------------
    logic clk_meta_q;
    logic clk_sync_q;
    logic dat_meta_q;
    logic dat_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            clk_meta_q <= 1'b1;
            clk_sync_q <= 1'b1;
            dat_meta_q <= 1'b1;
            dat_sync_q <= 1'b1;
        end else begin
            clk_meta_q <= bus.ps2_clk;
            clk_sync_q <= clk_meta_q;
            dat_meta_q <= bus.ps2_data;
            dat_sync_q <= dat_meta_q;
        end
    end

    // ------------------------------------------------------------------------
    // Clock de-glitch filter
    // The counter tracks how many consecutive samples disagreed with the
    // filtered level; since the line is one bit, disagreeing samples are all
    // equal to each other, so FILTER_LEN of them in a row flip the level. Any
    // agreeing sample restarts the count, which is what rejects short glitches.
    // ------------------------------------------------------------------------
    logic             filt_q;
    logic             filt_d;
    logic [c_FCW-1:0] filt_cnt_q;
    logic [c_FCW-1:0] filt_cnt_d;
    logic             fall_q;

    always_comb begin
        filt_d     = filt_q;
        filt_cnt_d = '0;
        if (clk_sync_q != filt_q) begin
            if (filt_cnt_q == c_FILT_LAST) begin
                filt_d = clk_sync_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            filt_q     <= 1'b1;
            filt_cnt_q <= '0;
            fall_q     <= 1'b0;
        end else begin
            filt_q     <= filt_d;
            filt_cnt_q <= filt_cnt_d;
            // One-cycle strobe on the filtered 1 -> 0 transition
            fall_q     <= filt_q & ~filt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Frame receiver
    // Data bits arrive LSB first and are shifted in from the top, so after
    // eight strobes the first bit sits in bit 0.
    // ------------------------------------------------------------------------
    rx_state_t        state_q;
    logic [2:0]       bit_cnt_q;
    logic [7:0]       shift_q;
    logic             par_q;
    logic [c_TCW-1:0] tmo_q;
    logic [7:0]       scan_code_q;
    logic             scan_valid_q;
    logic             frame_err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= 3'd0;
            shift_q      <= 8'h00;
            par_q        <= 1'b0;
            tmo_q        <= '0;
            scan_code_q  <= 8'h00;
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            scan_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;

            if (state_q == ST_IDLE) begin
                tmo_q <= '0;
                // A high level on a fall while idle is the tail of a frame we
                // never saw the start of; ignore it silently.
                if (fall_q && !dat_sync_q) begin
                    state_q   <= ST_DATA;
                    bit_cnt_q <= 3'd0;
                end
            end else if (fall_q) begin
                tmo_q <= '0;
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= {dat_sync_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= ST_PARITY;
                        end
                    end
                    ST_PARITY: begin
                        par_q   <= dat_sync_q;
                        state_q <= ST_STOP;
                    end
                    default: begin
                        // Stop bit must be high and the nine data+parity bits
                        // must contain an odd number of ones.
                        if (dat_sync_q && (^{shift_q, par_q})) begin
                            scan_code_q  <= shift_q;
                            scan_valid_q <= 1'b1;
                        end else begin
                            frame_err_q  <= 1'b1;
                        end
                        state_q <= ST_IDLE;
                    end
                endcase
            end else if (tmo_q == c_TMO_LAST) begin
                // Keyboard went quiet mid-frame: drop the partial byte
                tmo_q       <= '0;
                frame_err_q <= 1'b1;
                state_q     <= ST_IDLE;
            end else begin
                tmo_q <= tmo_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Key map lookup
    // Player 1 letters are only valid without the E0 prefix; arrows are only
    // valid with it (plain codes come from the numeric keypad). Enter is
    // accepted both as main-block (5A) and keypad (E0 5A).
    // ------------------------------------------------------------------------
    logic       ext_q;
    logic       brk_q;
    logic [9:0] keys_q;
    logic       w_hit;
    logic [3:0] w_idx;

    always_comb begin
        w_hit = 1'b0;
        w_idx = 4'd0;
        case (scan_code_q)
            8'h1D: begin w_hit = ~ext_q; w_idx = c_K_UP1;    end
            8'h1B: begin w_hit = ~ext_q; w_idx = c_K_DOWN1;  end
            8'h1C: begin w_hit = ~ext_q; w_idx = c_K_LEFT1;  end
            8'h23: begin w_hit = ~ext_q; w_idx = c_K_RIGHT1; end
            8'h29: begin w_hit = ~ext_q; w_idx = c_K_FIRE1;  end
            8'h75: begin w_hit =  ext_q; w_idx = c_K_UP2;    end
            8'h72: begin w_hit =  ext_q; w_idx = c_K_DOWN2;  end
            8'h6B: begin w_hit =  ext_q; w_idx = c_K_LEFT2;  end
            8'h74: begin w_hit =  ext_q; w_idx = c_K_RIGHT2; end
            8'h5A: begin w_hit = 1'b1;   w_idx = c_K_FIRE2;  end
            default: begin
                w_hit = 1'b0;
                w_idx = 4'd0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Make/break decoder
    // Prefix flags persist across frame errors and are consumed only by the
    // next good non-prefix byte, mapped or not.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            ext_q  <= 1'b0;
            brk_q  <= 1'b0;
            keys_q <= 10'b0;
        end else if (scan_valid_q) begin
            if (scan_code_q == c_CODE_EXT) begin
                ext_q <= 1'b1;
            end else if (scan_code_q == c_CODE_BRK) begin
                brk_q <= 1'b1;
            end else begin
                if (w_hit) begin
                    keys_q[w_idx] <= ~brk_q;
                end
                ext_q <= 1'b0;
                brk_q <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.up1        = keys_q[c_K_UP1];
    assign bus.down1      = keys_q[c_K_DOWN1];
    assign bus.left1      = keys_q[c_K_LEFT1];
    assign bus.right1     = keys_q[c_K_RIGHT1];
    assign bus.fire1      = keys_q[c_K_FIRE1];
    assign bus.up2        = keys_q[c_K_UP2];
    assign bus.down2      = keys_q[c_K_DOWN2];
    assign bus.left2      = keys_q[c_K_LEFT2];
    assign bus.right2     = keys_q[c_K_RIGHT2];
    assign bus.fire2      = keys_q[c_K_FIRE2];
    assign bus.scan_code  = scan_code_q;
    assign bus.scan_valid = scan_valid_q;
    assign bus.frame_err  = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_tank_controls.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ps2_tank_controls
//  Description : Self-checking bench for ps2_tank_controls. Drives PS/2 frames
//                bit by bit, keeps a keyboard-level model of the held keys and
//                prefix flags, and checks every cycle that the DUT outputs
//                match the model, that each scan_valid / frame_err pulse is
//                the expected one within its latency window, and that keys
//                move exactly one cycle after scan_valid.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ps2_tank_controls;

    localparam int FL   = 8;
    localparam int TMO  = 20000;
    localparam int H    = 15;   // half PS/2 bit period in clk cycles
    localparam int GAP  = 20;   // idle cycles between frames

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    ps2_tank_controls_if bus ();

    ps2_tank_controls #(
        .FILTER_LEN     (FL),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    logic [9:0] w_keys;
    assign w_keys = {bus.fire2, bus.right2, bus.left2, bus.down2, bus.up2,
                     bus.fire1, bus.right1, bus.left1, bus.down1, bus.up1};

    // ------------------------------------------------------------------------
    // Model state and expected-event queue
    // ------------------------------------------------------------------------
    typedef struct {
        bit         err;
        logic [7:0] code;
        logic [9:0] keys;
        int         cmin;
        int         cmax;
    } ev_t;

    ev_t        evq[$];
    logic [9:0] m_keys = '0;
    bit         m_ext  = 1'b0;
    bit         m_brk  = 1'b0;
    int         last_fall = 0;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Key index in the model vector for a byte, or -1 if unmapped
    function automatic int key_index(input logic [7:0] b, input bit ext);
        logic [7:0] p1 [5];
        logic [7:0] p2 [4];
        p1 = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29};
        p2 = '{8'h75, 8'h72, 8'h6B, 8'h74};
        if (b == 8'h5A) return 9;
        for (int i = 0; i < 5; i++) if (!ext && b == p1[i]) return i;
        for (int i = 0; i < 4; i++) if (ext && b == p2[i]) return 5 + i;
        return -1;
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hE0) begin
            m_ext = 1'b1;
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            k = key_index(b, m_ext);
            if (k >= 0) m_keys[k] = !m_brk;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        bus.ps2_data = b;
        tick(H);
        bus.ps2_clk = 1'b0;
        last_fall   = cyc;
        tick(H);
        bus.ps2_clk = 1'b1;
    endtask

    // kind: 0 good frame, 1 wrong parity, 2 stop bit low
    task automatic send_frame(input logic [7:0] b, input int kind);
        bit  par;
        ev_t e;
        par = ~^b;
        if (kind == 1) par = ~par;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(par);
        bus.ps2_data = (kind == 2) ? 1'b0 : 1'b1;
        tick(H);
        bus.ps2_clk = 1'b0;
        if (kind == 0) model_byte(b);
        e.err  = (kind != 0);
        e.code = b;
        e.keys = m_keys;
        e.cmin = cyc + FL + 2;
        e.cmax = cyc + FL + 6;
        evq.push_back(e);
        tick(H);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(GAP);
        chk("events_drained", 32'(evq.size()), 32'd0);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        m_keys = '0;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        evq.delete();
        tick(1);
        reset = 1'b0;
        tick(1);
    endtask

    // ------------------------------------------------------------------------
    // Per-cycle compare against the model
    // ------------------------------------------------------------------------
    logic [9:0] cur_keys = '0;
    logic [7:0] cur_code = '0;

    initial begin : compare
        ev_t        ce;
        logic [9:0] nxt_keys;
        forever begin
            @(negedge clk);
            if (reset) begin
                cur_keys = '0;
                cur_code = '0;
            end else begin
                nxt_keys = cur_keys;
                if (bus.scan_valid || bus.frame_err) begin
                    if (evq.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_event: scan_valid=%0b frame_err=%0b want none (cycle %0d)",
                                 bus.scan_valid, bus.frame_err, cyc);
                    end else begin
                        ce = evq.pop_front();
                        chk("event_frame_err", 32'(bus.frame_err), 32'(ce.err));
                        chk("event_scan_valid", 32'(bus.scan_valid), 32'(!ce.err));
                        chk("event_in_window", 32'(cyc >= ce.cmin && cyc <= ce.cmax), 32'd1);
                        if (!ce.err) cur_code = ce.code;
                        nxt_keys = ce.keys;
                    end
                end
                chk("scan_code", 32'(bus.scan_code), 32'(cur_code));
                chk("keys", 32'(w_keys), 32'(cur_keys));
                cur_keys = nxt_keys;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin : main
        logic [7:0] codes [10];
        logic [7:0] junk  [5];
        int         r;
        int         ki;
        bit         ext;
        logic [7:0] b;

        codes = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h29, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h5A};
        junk  = '{8'hAA, 8'hFA, 8'hFE, 8'hE0, 8'hF0};

        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        reset        = 1'b1;
        tick(5);
        reset = 1'b0;
        tick(2);

        chk("rst_keys", 32'(w_keys), 32'h0);
        chk("rst_scan_code", 32'(bus.scan_code), 32'h0);
        chk("rst_scan_valid", 32'(bus.scan_valid), 32'h0);
        chk("rst_frame_err", 32'(bus.frame_err), 32'h0);

        // W make
        send_frame(8'h1D, 0);
        chk("lit_up1_make", 32'(w_keys), 32'h001);
        chk("lit_model_up1", 32'(m_keys), 32'h001);
        chk("lit_code_1D", 32'(bus.scan_code), 32'h1D);

        // W break, then A make with no leftover break
        send_frame(8'hF0, 0);
        send_frame(8'h1D, 0);
        chk("lit_up1_break", 32'(w_keys), 32'h000);
        send_frame(8'h1C, 0);
        chk("lit_left1_make", 32'(w_keys), 32'h004);
        send_frame(8'hF0, 0);
        send_frame(8'h1C, 0);

        // Up arrow make / break, then keypad 8 (plain 75)
        send_frame(8'hE0, 0);
        send_frame(8'h75, 0);
        chk("lit_up2_make", 32'(w_keys), 32'h020);
        send_frame(8'hE0, 0);
        send_frame(8'hF0, 0);
        send_frame(8'h75, 0);
        chk("lit_up2_break", 32'(w_keys), 32'h000);
        send_frame(8'h75, 0);
        chk("lit_keypad_75", 32'(w_keys), 32'h000);
        chk("lit_code_75", 32'(bus.scan_code), 32'h75);

        // Space with bad parity, then good
        send_frame(8'h29, 1);
        chk("lit_fire1_badpar", 32'(w_keys), 32'h000);
        send_frame(8'h29, 0);
        chk("lit_fire1_make", 32'(w_keys), 32'h010);

        // Frame abandoned after 5 data bits
        begin
            ev_t e;
            send_bit(1'b0);
            for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
            e.err  = 1'b1;
            e.code = 8'h00;
            e.keys = m_keys;
            e.cmin = last_fall + TMO + FL + 2;
            e.cmax = last_fall + TMO + FL + 6;
            evq.push_back(e);
            bus.ps2_data = 1'b1;
            tick(25000);
            chk("timeout_drained", 32'(evq.size()), 32'd0);
        end
        send_frame(8'h5A, 0);
        chk("lit_fire2_after_tmo", 32'(w_keys), 32'h210);

        // Hold W and D, reset in the middle of a frame
        send_frame(8'h1D, 0);
        send_frame(8'h23, 0);
        chk("lit_w_d_held", 32'(w_keys), 32'h219);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        tick(3);
        do_reset();
        chk("lit_after_reset_keys", 32'(w_keys), 32'h000);
        chk("lit_after_reset_code", 32'(bus.scan_code), 32'h00);
        send_frame(8'h23, 0);
        chk("lit_right1_only", 32'(w_keys), 32'h008);

        // Glitch one sample short of the filter length, with data low
        bus.ps2_data = 1'b0;
        bus.ps2_clk  = 1'b0;
        tick(FL - 1);
        bus.ps2_clk  = 1'b1;
        bus.ps2_data = 1'b1;
        tick(30);
        send_frame(8'h1B, 0);
        chk("lit_glitch_then_down1", 32'(w_keys), 32'h00A);

        // Randomized traffic
        for (int n = 0; n < 40; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0) begin
                send_frame(8'($urandom_range(0, 255)), int'($urandom_range(1, 2)));
            end else if (r == 1) begin
                send_frame(junk[$urandom_range(0, 4)], 0);
            end else begin
                ki = int'($urandom_range(0, 9));
                if (ki >= 5 && ki <= 8) ext = ($urandom_range(0, 5) != 0);
                else                    ext = ($urandom_range(0, 5) == 0);
                b = codes[ki];
                if (ext) send_frame(8'hE0, 0);
                if ($urandom_range(0, 1) == 1) send_frame(8'hF0, 0);
                send_frame(b, 0);
            end
        end

        tick(10);
        chk("final_drained", 32'(evq.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
